// File: rtl/sweep_pkg.sv
// Shared definitions for the frequency-sweep sequencer.
// Provides the state encoding, default widths and the saturating adder used
// to derive delta_b from delta_a.
package sweep_pkg;

  localparam int unsigned SWEEP_DW = 12;
  localparam int unsigned SWEEP_CW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DWELL  = 2'd1,
    FINISH = 2'd2
  } sweep_state_t;

  // Unsigned add that pins to all-ones instead of wrapping.
  function automatic logic [SWEEP_DW-1:0] sat_add(input logic [SWEEP_DW-1:0] a,
                                                  input logic [SWEEP_DW-1:0] b);
    logic [SWEEP_DW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SWEEP_DW] ? {SWEEP_DW{1'b1}} : sum[SWEEP_DW-1:0];
  endfunction

endpackage

// File: rtl/sweep_dwell_cnt.sv
// Dwell counter for the sweep sequencer.
// Ports: clk, rst (async, active-low), clr (sync clear, wins over en),
//        en (count up), dwell (terminal count), expire (count == dwell).
module sweep_dwell_cnt
  import sweep_pkg::*;
#(
  parameter int unsigned CW = SWEEP_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] dwell,
  output logic          expire
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority so a new point always starts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == dwell);

endmodule

// File: rtl/sine_sweep_ctrl.sv
// Frequency-sweep sequencer for the NCO pair feeding the sine subtractor.
// Steps delta_a from f_start to f_stop by f_step, holding each point for
// dwell+1 cycles; delta_b follows delta_a plus a saturating offset.
// Ports: clk, rst (async, active-low), start/abort (host control),
//        f_start/f_stop/f_step/offset/dwell (sweep config, latched on start),
//        delta_a/delta_b (registered increments), busy, done, step_strobe.
module sine_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned DW = SWEEP_DW,
  parameter int unsigned CW = SWEEP_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] f_start,
  input  logic [DW-1:0] f_stop,
  input  logic [DW-1:0] f_step,
  input  logic [DW-1:0] offset,
  input  logic [CW-1:0] dwell,
  output logic [DW-1:0] delta_a,
  output logic [DW-1:0] delta_b,
  output logic          busy,
  output logic          done,
  output logic          step_strobe
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_DWELL  = DWELL;
  localparam logic [1:0] ST_FINISH = FINISH;

  logic [1:0]    state_q,   state_d;
  logic [DW-1:0] f_stop_q,  f_stop_d;
  logic [DW-1:0] f_step_q,  f_step_d;
  logic [DW-1:0] offset_q,  offset_d;
  logic [CW-1:0] dwell_q,   dwell_d;
  logic          dir_dn_q,  dir_dn_d;
  logic [DW-1:0] delta_a_q, delta_a_d;
  logic [DW-1:0] delta_b_q, delta_b_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          strobe_q,  strobe_d;

  logic          cnt_clr;
  logic          cnt_en;
  logic          expire;
  logic [DW:0]   up_sum;
  logic [DW:0]   dn_diff;
  logic [DW-1:0] next_pt;

  sweep_dwell_cnt #(
    .CW(CW)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .dwell (dwell_q),
    .expire(expire)
  );

  // Next sweep point, computed one bit wider so overshoot/underflow is visible.
  always_comb begin
    up_sum  = {1'b0, delta_a_q} + {1'b0, f_step_q};
    dn_diff = {1'b0, delta_a_q} - {1'b0, f_step_q};
    next_pt = f_stop_q;
    if (dir_dn_q) begin
      if (!dn_diff[DW] && (dn_diff[DW-1:0] >= f_stop_q)) begin
        next_pt = dn_diff[DW-1:0];
      end
    end else begin
      if (up_sum <= {1'b0, f_stop_q}) begin
        next_pt = up_sum[DW-1:0];
      end
    end
  end

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    f_stop_d  = f_stop_q;
    f_step_d  = f_step_q;
    offset_d  = offset_q;
    dwell_d   = dwell_q;
    dir_dn_d  = dir_dn_q;
    delta_a_d = delta_a_q;
    delta_b_d = delta_b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    strobe_d  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          f_stop_d  = f_stop;
          f_step_d  = f_step;
          offset_d  = offset;
          dwell_d   = dwell;
          dir_dn_d  = (f_start > f_stop);
          delta_a_d = f_start;
          delta_b_d = DW'(sat_add(SWEEP_DW'(f_start), SWEEP_DW'(offset)));
          busy_d    = 1'b1;
          strobe_d  = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = ST_DWELL;
        end
      end

      ST_DWELL: begin
        if (abort) begin
          delta_a_d = '0;
          delta_b_d = '0;
          busy_d    = 1'b0;
          cnt_clr   = 1'b1;
          state_d   = ST_IDLE;
        end else if (expire) begin
          cnt_clr = 1'b1;
          if ((delta_a_q == f_stop_q) || (f_step_q == '0)) begin
            // done and busy-low land together on the FINISH cycle.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            delta_a_d = next_pt;
            delta_b_d = DW'(sat_add(SWEEP_DW'(next_pt), SWEEP_DW'(offset_q)));
            strobe_d  = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_FINISH: begin
        if (abort) begin
          delta_a_d = '0;
          delta_b_d = '0;
        end
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      f_stop_q  <= '0;
      f_step_q  <= '0;
      offset_q  <= '0;
      dwell_q   <= '0;
      dir_dn_q  <= 1'b0;
      delta_a_q <= '0;
      delta_b_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      f_stop_q  <= f_stop_d;
      f_step_q  <= f_step_d;
      offset_q  <= offset_d;
      dwell_q   <= dwell_d;
      dir_dn_q  <= dir_dn_d;
      delta_a_q <= delta_a_d;
      delta_b_q <= delta_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      strobe_q  <= strobe_d;
    end
  end

  assign delta_a     = delta_a_q;
  assign delta_b     = delta_b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign step_strobe = strobe_q;

endmodule

// File: doc/sine_sweep_ctrl.md
# sine_sweep_ctrl

Frequency-sweep sequencer for the NCO pair in the sine-difference datapath. It steps the phase increment `delta_a` from a programmed start value to a stop value in fixed increments. Each point is held for a programmable dwell time. `delta_b` tracks `delta_a` plus a fixed offset. The block drives the `delta_a`/`delta_b` inputs of the sine subtractor stage, with a start/busy/done handshake toward the host sequencer.

## Interface
Parameters:
- `DW`, 12: phase-increment width.
- `CW`, 16: dwell counter width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: sweep request. Sampled only in IDLE.
- `abort` in 1: terminates the sweep. Has priority over all other events except reset.
- `f_start` in DW: first increment.
- `f_stop` in DW: last increment.
- `f_step` in DW: step magnitude.
- `offset` in DW: `delta_b` offset.
- `dwell` in CW: the hold time per point is `dwell`+1 cycles.
- `delta_a` out DW: registered increment for NCO A.
- `delta_b` out DW: registered increment for NCO B.
- `busy` out 1: high while a sweep runs.
- `done` out 1: one-cycle pulse after the last point completes.
- `step_strobe` out 1: one-cycle pulse in every cycle where a new point is loaded.

## Operation
- States: IDLE, DWELL, FINISH.
- IDLE with `start`=1:
  - Latch `f_start`, `f_stop`, `f_step`, `offset` and `dwell`. Inputs changing afterward have no effect.
  - Load `delta_a`=`f_start`, clear the dwell counter, pulse `step_strobe`, go to DWELL.
- Direction: down if latched `f_start` > `f_stop`, otherwise up.
- DWELL: the counter increments each cycle. When the counter equals `dwell`:
  - If `delta_a` == `f_stop`, or `f_step` == 0: go to FINISH.
  - Otherwise load the next point, clear the counter and pulse `step_strobe`.
- Next point arithmetic is computed in DW+1 bits, unsigned:
  - Up: `delta_a`+`f_step`, clamped to `f_stop` if it would exceed it.
  - Down: `delta_a`−`f_step`, clamped to `f_stop` if it would fall below it. No wrap-around is possible.
- FINISH: pulse `done` for one cycle, then go to IDLE. `delta_a`/`delta_b` hold the last point.
- `delta_b` = min(`delta_a`+`offset`, 2^DW−1). It saturates, and is registered in the same cycle as `delta_a`.
- `f_start` == `f_stop`, or `f_step` == 0, gives a single point held for `dwell`+1 cycles, then `done`.
- `start` while not in IDLE is ignored and is not queued.
- `abort` in DWELL or FINISH:
  - Next cycle: IDLE, `busy`=0, `delta_a`=`delta_b`=0, no `done`.
  - `abort` together with `start` in IDLE: `start` is ignored.
- Reset, including mid-sweep: IDLE; `delta_a`, `delta_b`, `busy`, `done`, `step_strobe` and the counter are all 0.

## Timing
- `start` sampled at edge 0. From cycle 1: `delta_a`=`f_start`, `busy`=1, `step_strobe`=1.
- Each point is visible for exactly `dwell`+1 cycles. No gap cycles between points.
- For N points, `done`=1 in cycle N·(`dwell`+1)+1. `busy` falls in that same cycle.
- Earliest restart: a `start` sampled in the cycle after `done`.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `sweep_pkg`:
  - State enum `sweep_state_t` {IDLE, DWELL, FINISH}.
  - Constants `SWEEP_DW`=12 and `SWEEP_CW`=16.
  - Function `sat_add` (saturating DW-bit add), used for `delta_b`.
- One sub-module, `sweep_dwell_cnt`: CW-bit counter with synchronous clear and an `expire` output (count == `dwell`).
- The FSM, step arithmetic and output registers live in the top module.

## Test plan
- Up sweep, exact steps: `f_start`=100, `f_stop`=130, `f_step`=10, `dwell`=2, `offset`=5.
  - `delta_a` = 100/110/120/130 in cycles 1–3/4–6/7–9/10–12.
  - `delta_b` = 105..135.
  - `step_strobe` pulses in cycles 1, 4, 7, 10; `done` in cycle 13.
- Overshoot clamp: 100→125, step 10, `dwell`=0.
  - `delta_a` = 100, 110, 120, 125 in cycles 1–4; `done` in cycle 5.
- Down sweep: 200→170, step 15, `dwell`=1.
  - `delta_a` = 200, 185, 170; `done` in cycle 7.
- Saturation and degenerate step: `f_start`=`f_stop`=4090, `offset`=20, `f_step`=0, `dwell`=3.
  - `delta_b`=4095 in cycles 1–4; `done` in cycle 5.
- Abort and ignored start: re-pulse `start` in cycle 2 of the first sweep, then `abort` in cycle 5.
  - The second `start` has no effect.
  - Cycle 6: `busy`=0, deltas=0, no `done`.
  - A new `start` in cycle 6 begins a fresh sweep.
- Reset mid-sweep: assert `rst`=0 asynchronously in cycle 7 of the first test.
  - All outputs are 0 immediately.
  - After release, the block stays in IDLE until `start`.
